// File: rtl/maxnet_controller.sv
// MAXNET winner-take-all sequencer: loads four activations, iterates an
// external datapath until at most one neuron stays positive (or the iteration
// cap is hit), then reports the winning index and its value.
module maxnet_controller #(
  parameter int unsigned MAX_ITER = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_en,
  input  logic [31:0] a_in [0:3],
  output logic [31:0] a_cur [0:3],
  output logic        calc_req,
  input  logic        res_valid,
  input  logic [31:0] res_in [0:3],
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] winner_val,
  output logic        timeout,
  output logic [3:0]  iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_REQ = 3'd1,
    S_LOAD     = 3'd2,
    S_CHECK    = 3'd3,
    S_CALC     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0] MAX_ITER_C = 4'(MAX_ITER);

  // ReLU on raw IEEE-754 words: negatives and both zeros become +0.
  function automatic logic [31:0] relu(input logic [31:0] x);
    logic [31:0] r;
    if (x[31] || (x[30:0] == 31'd0)) begin
      r = 32'd0;
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] a_cur_q [0:3];
  logic [31:0] a_cur_d [0:3];
  logic        mem_en_q, mem_en_d;
  logic        calc_req_q, calc_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  winner_q, winner_d;
  logic [31:0] winner_val_q, winner_val_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  iter_cnt_q, iter_cnt_d;

  logic [2:0]  nz_cnt_s;
  logic [1:0]  max_idx_s;
  logic [31:0] max_val_s;

  // Survivor count and unsigned maximum over a_cur (strict > keeps lowest index on ties).
  always_comb begin
    nz_cnt_s  = 3'd0;
    max_idx_s = 2'd0;
    max_val_s = a_cur_q[0];
    for (int i = 0; i < 4; i++) begin
      if (a_cur_q[i][30:0] != 31'd0) begin
        nz_cnt_s = nz_cnt_s + 3'd1;
      end else begin
        nz_cnt_s = nz_cnt_s;
      end
    end
    for (int i = 1; i < 4; i++) begin
      if (a_cur_q[i] > max_val_s) begin
        max_val_s = a_cur_q[i];
        max_idx_s = 2'(i);
      end else begin
        max_val_s = max_val_s;
      end
    end
  end

  // Next-state and next-output computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d      = state_q;
    a_cur_d      = a_cur_q;
    winner_d     = winner_q;
    winner_val_d = winner_val_q;
    timeout_d    = timeout_q;
    iter_cnt_d   = iter_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_REQ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        for (int i = 0; i < 4; i++) begin
          a_cur_d[i] = relu(a_in[i]);
        end
        iter_cnt_d = 4'd0;
        timeout_d  = 1'b0;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (nz_cnt_s <= 3'd1) begin
          // With no survivors the max search already yields index 0, value 0.
          state_d      = S_DONE;
          timeout_d    = 1'b0;
          winner_d     = max_idx_s;
          winner_val_d = max_val_s;
        end else if (iter_cnt_q == MAX_ITER_C) begin
          state_d      = S_DONE;
          timeout_d    = 1'b1;
          winner_d     = max_idx_s;
          winner_val_d = max_val_s;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (res_valid) begin
          for (int i = 0; i < 4; i++) begin
            a_cur_d[i] = relu(res_in[i]);
          end
          if (iter_cnt_q == 4'd15) begin
            iter_cnt_d = 4'd15;
          end else begin
            iter_cnt_d = iter_cnt_q + 4'd1;
          end
          state_d = S_CHECK;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_en_d   = (state_d == S_LOAD_REQ);
    calc_req_d = (state_d == S_CALC);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs; reset aborts any run and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_en_q     <= 1'b0;
      calc_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= 2'd0;
      winner_val_q <= 32'd0;
      timeout_q    <= 1'b0;
      iter_cnt_q   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        a_cur_q[i] <= 32'd0;
      end
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      calc_req_q   <= calc_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      winner_q     <= winner_d;
      winner_val_q <= winner_val_d;
      timeout_q    <= timeout_d;
      iter_cnt_q   <= iter_cnt_d;
      for (int i = 0; i < 4; i++) begin
        a_cur_q[i] <= a_cur_d[i];
      end
    end
  end

  assign mem_en     = mem_en_q;
  assign calc_req   = calc_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign winner     = winner_q;
  assign winner_val = winner_val_q;
  assign timeout    = timeout_q;
  assign iter_cnt   = iter_cnt_q;
  assign a_cur      = a_cur_q;

endmodule
